// File: rtl/serial_xs3_codec_if.sv
// serial_xs3_codec_if: serial bit stream in, registered serial/parallel result out.
interface serial_xs3_codec_if #(parameter int WIDTH = 5);
  logic in_valid, in_bit, in_first, mode;
  logic out_valid, out_bit, word_done, err;
  logic [WIDTH-1:0] out_word;
  modport master(output in_valid, in_bit, in_first, mode,
                 input out_valid, out_bit, out_word, word_done, err);
  modport slave(input in_valid, in_bit, in_first, mode,
                output out_valid, out_bit, out_word, word_done, err);
endinterface

// File: rtl/serial_xs3_codec.sv
// serial_xs3_codec: LSB-first bit-serial add/subtract of OFFSET per WIDTH-bit word.
module serial_xs3_codec #(
  parameter int WIDTH  = 5,
  parameter int OFFSET = 3
) (
  input logic clk,
  input logic rst,
  serial_xs3_codec_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);
  typedef enum logic {S_C0, S_C1} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, i;
  logic mode_q, mode_d, first, m, a, c, k, r, cn, last;
  logic [WIDTH-1:0] part_q, part_d, word_d, out_word_q;
  logic out_valid_q, out_bit_q, out_bit_d, word_done_q, err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_C0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      part_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      word_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      part_q      <= part_d;
      out_word_q  <= word_d;
      out_valid_q <= bus.in_valid;
      out_bit_q   <= out_bit_d;
      word_done_q <= bus.in_valid & last;
      err_q       <= bus.in_valid & last & cn;
    end
  end
  // A bit flagged in_first, or arriving at index 0, restarts with no carry and a fresh mode.
  always_comb begin
    first = bus.in_first | idx_q == '0;
    i     = first ? '0 : idx_q;
    c     = !first && state_q == S_C1;
    m     = first ? bus.mode : mode_q;
    a     = bus.in_bit;
    k     = OFF[i];
    r     = a ^ k ^ c;
    cn    = m ? (a & k | a & c | k & c) : (~a & k | ~a & c | k & c);
    last  = i == IW'(WIDTH - 1);
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    part_d    = part_q;
    word_d    = out_word_q;
    out_bit_d = out_bit_q;
    if (bus.in_valid) begin
      state_d   = (cn && !last) ? S_C1 : S_C0;
      idx_d     = last ? '0 : i + IW'(1);
      mode_d    = m;
      part_d    = first ? '0 : part_q;
      part_d[i] = r;
      word_d    = last ? part_d : out_word_q;
      out_bit_d = r;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_word  = out_word_q;
  assign bus.word_done = word_done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_serial_xs3_codec.sv
// tb_serial_xs3_codec: vector table, corner sequences and random words against a word-level model.
module tb_serial_xs3_codec;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  serial_xs3_codec_if #(.WIDTH(5)) b5();
  serial_xs3_codec_if #(.WIDTH(8)) b8();
  serial_xs3_codec #(.WIDTH(5), .OFFSET(3)) dut5(.clk(clk), .rst(rst), .bus(b5.slave));
  serial_xs3_codec #(.WIDTH(8), .OFFSET(51)) dut8(.clk(clk), .rst(rst), .bus(b8.slave));
  int vecs = 0;
  int errs = 0;
  typedef struct {logic [4:0] x; logic m; logic [4:0] w; logic e;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Word-level reference: result in low w bits, carry/borrow flag at bit w.
  function automatic int model(input int x, input int m, input int w, input int off);
    int o, v, e;
    o = off % (1 << w);
    v = m ? x + o : x - o;
    e = (v < 0 || v >= (1 << w)) ? 1 : 0;
    return (e << w) | (v & ((1 << w) - 1));
  endfunction
  task automatic send5(input logic [4:0] x, input logic m, input logic first, input int nbits,
                       input int stall_at, input int stall_n, output int pulses);
    int e;
    logic [4:0] ew;
    logic ee;
    e = model(int'(x), int'(m), 5, 3);
    ew = e[4:0];
    ee = e[5];
    pulses = 0;
    for (int i = 0; i < nbits; i++) begin
      b5.in_valid = 1'b1;
      b5.in_bit = x[i];
      b5.in_first = (i == 0) && first;
      b5.mode = (i == 0) ? m : ~m;
      @(posedge clk); #1;
      pulses += int'(b5.out_valid);
      chk("out_valid", 32'(b5.out_valid), 32'd1);
      chk("out_bit", 32'(b5.out_bit), 32'(ew[i]));
      chk("word_done", 32'(b5.word_done), 32'(i == 4));
      chk("err", 32'(b5.err), (i == 4) ? 32'(ee) : 32'd0);
      if (i == 4) chk("out_word", 32'(b5.out_word), 32'(ew));
      if (i == stall_at)
        for (int s = 0; s < stall_n; s++) begin
          b5.in_valid = 1'b0;
          b5.in_first = 1'b1;
          b5.mode = ~b5.mode;
          b5.in_bit = ~b5.in_bit;
          @(posedge clk); #1;
          pulses += int'(b5.out_valid);
          chk("stall_valid", 32'(b5.out_valid), 32'd0);
          chk("stall_done", 32'(b5.word_done), 32'd0);
          chk("stall_hold", 32'(b5.out_bit), 32'(ew[i]));
        end
    end
  endtask
  task automatic idle5();
    b5.in_valid = 1'b0;
    b5.in_first = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(b5.out_valid), 32'd0);
  endtask
  task automatic send8(input logic [7:0] x, input logic m);
    int e;
    e = model(int'(x), int'(m), 8, 51);
    for (int i = 0; i < 8; i++) begin
      b8.in_valid = 1'b1;
      b8.in_bit = x[i];
      b8.in_first = 1'b0;
      b8.mode = (i == 0) ? m : ~m;
      @(posedge clk); #1;
      chk("w8_bit", 32'(b8.out_bit), 32'(e[i]));
      chk("w8_done", 32'(b8.word_done), 32'(i == 7));
    end
    chk("w8_word", 32'(b8.out_word), 32'(e[7:0]));
    chk("w8_err", 32'(b8.err), 32'(e[8]));
    b8.in_valid = 1'b0;
  endtask
  initial begin
    int p;
    tbl[0] = '{5'd8,  1'b0, 5'd5,  1'b0};
    tbl[1] = '{5'd2,  1'b0, 5'd31, 1'b1};
    tbl[2] = '{5'd6,  1'b1, 5'd9,  1'b0};
    tbl[3] = '{5'd30, 1'b1, 5'd1,  1'b1};
    tbl[4] = '{5'd3,  1'b0, 5'd0,  1'b0};
    tbl[5] = '{5'd0,  1'b0, 5'd29, 1'b1};
    tbl[6] = '{5'd28, 1'b1, 5'd31, 1'b0};
    tbl[7] = '{5'd29, 1'b1, 5'd0,  1'b1};
    {b5.in_valid, b5.in_bit, b5.in_first, b5.mode} = 4'b0;
    {b8.in_valid, b8.in_bit, b8.in_first, b8.mode} = 4'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst5", {b5.out_valid, b5.out_bit, b5.word_done, b5.err, 23'd0, b5.out_word}, 32'd0);
    chk("rst8", {b8.out_valid, b8.out_bit, b8.word_done, b8.err, 20'd0, b8.out_word}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    // Table words run back-to-back; out_word/err checked against the constants.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 5; i++) begin
        b5.in_valid = 1'b1;
        b5.in_bit = tbl[n].x[i];
        b5.in_first = 1'b0;
        b5.mode = (i == 0) ? tbl[n].m : ~tbl[n].m;
        @(posedge clk); #1;
        chk("tbl_bit", 32'(b5.out_bit), 32'(tbl[n].w[i]));
        chk("tbl_done", 32'(b5.word_done), 32'(i == 4));
      end
      chk("tbl_word", 32'(b5.out_word), 32'(tbl[n].w));
      chk("tbl_err", 32'(b5.err), 32'(tbl[n].e));
    end
    idle5();
    chk("done_drop", 32'(b5.word_done), 32'd0);
    send5(5'd12, 1'b0, 1'b1, 5, 2, 3, p);
    chk("stall_pulses", 32'(p), 32'd5);
    chk("stall_word", 32'(b5.out_word), 32'd9);
    idle5();
    send5(5'd21, 1'b1, 1'b0, 3, 9, 0, p);
    send5(5'd8, 1'b0, 1'b1, 5, 9, 0, p);
    chk("resync_word", 32'(b5.out_word), 32'd5);
    idle5();
    send5(5'd8, 1'b0, 1'b0, 5, 9, 0, p);
    send5(5'd17, 1'b1, 1'b0, 3, 9, 0, p);
    b5.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid", {b5.out_valid, b5.out_bit, b5.word_done, b5.err, 23'd0, b5.out_word}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    send5(5'd8, 1'b0, 1'b0, 5, 9, 0, p);
    chk("post_rst", 32'(b5.out_word), 32'd5);
    idle5();
    send8(8'h80, 1'b0);
    send8(8'h10, 1'b0);
    for (int n = 0; n < 20; n++) send8(8'($urandom), 1'($urandom));
    for (int n = 0; n < 150; n++)
      send5(5'($urandom), 1'($urandom), 1'($urandom), 5,
            int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), p);
    idle5();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
